arb8_scheduler: RTL

ARB8_SCHEDULER -- requirements
Module: arb8_scheduler

---
 rtl/arb8_scheduler.sv | 115 +++++++++++
 1 files changed

// File: rtl/arb8_scheduler.sv
// arb8_scheduler: 8-way round-robin grant scheduler with registered outputs and a GAP cycle between grants.
// Optional hold timer enabled by `define ARB8_SCHEDULER_TIMEOUT_EN (forced release after HOLD_MAX cycles).
`default_nettype none

module arb8_scheduler #(
    parameter int HOLD_MAX = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] REQ,
    output logic [7:0] GNT,
    output logic [2:0] GNT_IDX,
    output logic       GNT_VALID,
    output logic       TIMEOUT
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_range_check
        $error("arb8_scheduler: HOLD_MAX must be within 2..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] win_idx;
    logic [2:0] scan_idx;

    // Rotating priority scan starting at ptr; win_idx is only used when REQ != 0.
    always_comb begin
        win_idx  = ptr;
        scan_idx = ptr;
        for (int k = 7; k >= 0; k--) begin
            scan_idx = ptr + 3'(k);
            if (REQ[scan_idx]) begin
                win_idx = scan_idx;
            end
        end
    end

`ifdef ARB8_SCHEDULER_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] hold_cnt;
`else
    assign TIMEOUT = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            GNT       <= 8'd0;
            GNT_IDX   <= 3'd0;
            GNT_VALID <= 1'b0;
`ifdef ARB8_SCHEDULER_TIMEOUT_EN
            hold_cnt  <= '0;
            TIMEOUT   <= 1'b0;
`endif
        end else begin
`ifdef ARB8_SCHEDULER_TIMEOUT_EN
            TIMEOUT <= 1'b0;
`endif
            case (state)
                IDLE, GAP: begin
                    if (|REQ) begin
                        state     <= GRANT;
                        GNT       <= 8'd1 << win_idx;
                        GNT_IDX   <= win_idx;
                        GNT_VALID <= 1'b1;
`ifdef ARB8_SCHEDULER_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    // A voluntary release wins over a timeout landing on the same edge.
                    if (!REQ[GNT_IDX]) begin
                        state     <= GAP;
                        ptr       <= GNT_IDX + 3'd1;
                        GNT       <= 8'd0;
                        GNT_IDX   <= 3'd0;
                        GNT_VALID <= 1'b0;
`ifdef ARB8_SCHEDULER_TIMEOUT_EN
                    end else if (hold_cnt == CNT_LAST) begin
                        state     <= GAP;
                        ptr       <= GNT_IDX + 3'd1;
                        GNT       <= 8'd0;
                        GNT_IDX   <= 3'd0;
                        GNT_VALID <= 1'b0;
                        TIMEOUT   <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    GNT       <= 8'd0;
                    GNT_IDX   <= 3'd0;
                    GNT_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
